// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM states, operation
// encodings and the default geometry used by the CPU's memory port.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam int DEFAULT_DEPTH       = 512;
   localparam int DEFAULT_WAIT_STATES = 2;

   // A request is legal only when exactly one strobe is raised.
   function automatic logic is_single_request(input logic rd, input logic wr);
      return rd ^ wr;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage behind the responder: synchronous write, registered read.
// The read register only updates when re is asserted, so q holds between accesses.
module mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Read-first: a write access returns the word as it was before the commit.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= d;
      end
      if (re) begin
         q <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR port: latches one request, waits
// WAIT_STATES cycles, performs the access and holds done until the strobes drop.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              busy,
   output logic              err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t            state, state_n;
   logic [3:0]        count, count_n;
   op_t               op, op_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic              err_n;
   logic              use_array, use_array_n;
   logic              in_range;
   logic              access;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_q;

   assign in_range = {1'b0, addr_q} < (ADDR_W + 1)'(DEPTH);

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= ST_IDLE;
         count     <= '0;
         op        <= OP_RD;
         addr_q    <= '0;
         wdata_q   <= '0;
         err       <= 1'b0;
         use_array <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         op        <= op_n;
         addr_q    <= addr_n;
         wdata_q   <= wdata_n;
         err       <= err_n;
         use_array <= use_array_n;
      end
   end

   // Abort takes priority over the access edge so a dropped write never commits.
   always_comb begin
      state_n     = state;
      count_n     = count;
      op_n        = op;
      addr_n      = addr_q;
      wdata_n     = wdata_q;
      use_array_n = use_array;
      err_n       = 1'b0;
      access      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (read && write) begin
               err_n = 1'b1;
            end else if (is_single_request(read, write)) begin
               op_n    = write ? OP_WR : OP_RD;
               addr_n  = addr;
               wdata_n = wdata;
               count_n = 4'(WAIT_STATES);
               state_n = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!read && !write) begin
               state_n = ST_IDLE;
            end else if (count == 4'd0) begin
               access      = 1'b1;
               use_array_n = in_range;
               err_n       = !in_range;
               state_n     = ST_DONE;
            end else begin
               count_n = count - 4'd1;
            end
         end
         ST_DONE: begin
            if (!read && !write) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign mem_we = access && (op == OP_WR) && in_range && !clr;
   assign mem_re = access && in_range && !clr;

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_array (
      .clk  (clk),
      .we   (mem_we),
      .re   (mem_re),
      .addr (addr_q[AW-1:0]),
      .d    (wdata_q),
      .q    (mem_q)
   );

   // Out-of-range reads and the post-reset state present zero instead of the array register.
   assign rdata = use_array ? mem_q : '0;
   assign done  = (state == ST_DONE);
   assign busy  = (state == ST_BUSY);

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against a word-level
// reference memory (associative array of written words).
module tb_mem_responder;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 256;
   localparam int WS     = 2;

   logic              clk;
   logic              clr;
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              done;
   logic              busy;
   logic              err;

   int compared;
   int mismatched;
   logic [DATA_W-1:0] ref_mem [int];

   mem_responder #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .DEPTH       (DEPTH),
      .WAIT_STATES (WS)
   ) dut (
      .clk   (clk),
      .clr   (clr),
      .read  (read),
      .write (write),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .done  (done),
      .busy  (busy),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One complete transaction, optionally holding the strobe after done while
   // scrambling addr/wdata to show the latched request is what counts.
   task automatic applyStimulus(input bit is_write, input int a, input logic [DATA_W-1:0] d,
                                input int hold_after);
      int cycles;
      bit have_exp;
      logic [DATA_W-1:0] exp_rd;
      read  = !is_write;
      write = is_write;
      addr  = ADDR_W'(a);
      wdata = d;
      tick();
      checkOutput("busy_after_sample", {31'd0, busy}, 32'd1);
      cycles = 0;
      while (!done && cycles < 20) begin
         tick();
         cycles++;
      end
      checkOutput("latency", cycles, WS + 1);
      checkOutput("err_on_access", {31'd0, err}, {31'd0, a >= DEPTH});
      have_exp = 1'b0;
      exp_rd   = '0;
      if (!is_write) begin
         if (a >= DEPTH) begin
            have_exp = 1'b1;
         end else if (ref_mem.exists(a)) begin
            have_exp = 1'b1;
            exp_rd   = ref_mem[a];
         end
         if (have_exp) checkOutput("rdata", rdata, exp_rd);
      end else if (a < DEPTH) begin
         ref_mem[a] = d;
      end
      for (int i = 0; i < hold_after; i++) begin
         addr  = ADDR_W'($urandom);
         wdata = $urandom;
         tick();
         checkOutput("done_held", {31'd0, done}, 32'd1);
         checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
         if (have_exp) checkOutput("rdata_held", rdata, exp_rd);
      end
      read  = 1'b0;
      write = 1'b0;
      tick();
      checkOutput("done_falls", {31'd0, done}, 32'd0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      clr   = 1'b1;
      read  = 1'b0;
      write = 1'b0;
      addr  = '0;
      wdata = '0;
      tick();
      tick();
      checkOutput("reset_rdata", rdata, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);
      clr = 1'b0;
      tick();

      // Basic write then read-back.
      applyStimulus(1'b1, 5, 32'hDEADBEEF, 0);
      applyStimulus(1'b0, 5, 32'h0, 0);

      // Hold read after done, then re-raise for a second access.
      applyStimulus(1'b0, 5, 32'h0, 3);
      applyStimulus(1'b0, 5, 32'h0, 0);

      // Both strobes together in IDLE.
      read  = 1'b1;
      write = 1'b1;
      addr  = ADDR_W'(5);
      wdata = 32'h0BAD0BAD;
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("dual_err", {31'd0, err}, 32'd1);
         checkOutput("dual_busy", {31'd0, busy}, 32'd0);
      end
      read  = 1'b0;
      write = 1'b0;
      tick();
      checkOutput("dual_err_clears", {31'd0, err}, 32'd0);
      applyStimulus(1'b0, 5, 32'h0, 0);

      // Out-of-range write must not alias onto addr 300 mod 256.
      applyStimulus(1'b1, 44, 32'h44444444, 0);
      applyStimulus(1'b1, 300, 32'h00001234, 0);
      applyStimulus(1'b0, 300, 32'h0, 0);
      applyStimulus(1'b0, 44, 32'h0, 0);

      // Abort a write during BUSY.
      applyStimulus(1'b1, 7, 32'h77777777, 0);
      write = 1'b1;
      addr  = ADDR_W'(7);
      wdata = 32'hA5A5A5A5;
      tick();
      tick();
      write = 1'b0;
      tick();
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("abort_no_done", {31'd0, done}, 32'd0);
      end
      applyStimulus(1'b0, 7, 32'h0, 0);

      // clr during BUSY of a write.
      applyStimulus(1'b1, 9, 32'h99999999, 0);
      write = 1'b1;
      addr  = ADDR_W'(9);
      wdata = 32'h12345678;
      tick();
      tick();
      clr = 1'b1;
      tick();
      checkOutput("clr_done", {31'd0, done}, 32'd0);
      checkOutput("clr_busy", {31'd0, busy}, 32'd0);
      checkOutput("clr_rdata", rdata, 32'd0);
      clr   = 1'b0;
      write = 1'b0;
      tick();
      applyStimulus(1'b0, 9, 32'h0, 0);

      // Randomised traffic, including out-of-range addresses.
      for (int n = 0; n < 40; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 299)), $urandom,
                       int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
